mem_arbiter_unit: RTL and testbench



---
 rtl/mem_arbiter_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_arbiter_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_unit.sv
`default_nettype none
// ============================================================================
// mem_arbiter_unit
// Round-robin arbiter sequencing byte/half/word transfers from several
// requesters over a single 8-bit RAM/IO bus.
// Revision: 1.0
// ============================================================================
module mem_arbiter_unit #(
  parameter int                   NUM_PORTS  = 2,
  parameter int                   ADDR_W     = 32,
  parameter logic [31:0]          IO_BASE    = 32'h0003_0000,
  parameter logic [NUM_PORTS-1:0] FLUSH_MASK = {NUM_PORTS{1'b1}}
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic [7:0]                  mem_din,
  output logic [7:0]                  mem_dout,
  output logic [31:0]                 mem_a,
  output logic                        mem_wr,
  input  logic                        io_buffer_full,
  input  logic                        flush_in,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_wr,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*3-1:0]      req_len,
  input  logic [NUM_PORTS*32-1:0]     req_wdata,
  output logic [NUM_PORTS-1:0]        resp_valid,
  output logic [31:0]                 resp_data
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PW-1:0]     port_q, port_d;
  logic [PW-1:0]     last_q, last_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        len_q, len_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        k_q, k_d;
  logic [1:0]        lastk_q, lastk_d;
  logic [31:0]       data_q, data_d;

  logic [ADDR_W-1:0] w_addr_arr  [NUM_PORTS];
  logic [2:0]        w_len_arr   [NUM_PORTS];
  logic [31:0]       w_wdata_arr [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign w_addr_arr[p]  = req_addr[p*ADDR_W +: ADDR_W];
    assign w_len_arr[p]   = req_len[p*3 +: 3];
    assign w_wdata_arr[p] = req_wdata[p*32 +: 32];
  end

  logic [NUM_PORTS-1:0] w_elig;
  logic                 w_found;
  logic [PW-1:0]        w_grant;
  int                   w_idx;

  assign w_elig = req_valid & ~(flush_in ? FLUSH_MASK : '0);

  // Scan downward so the last hit is the nearest port after last_q.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      w_idx = int'(last_q) + i;
      if (w_idx >= NUM_PORTS) w_idx = w_idx - NUM_PORTS;
      if (w_elig[PW'(w_idx)]) begin
        w_found = 1'b1;
        w_grant = PW'(w_idx);
      end
    end
  end

  logic [ADDR_W-1:0] w_cur;
  logic [31:0]       w_cur32;
  logic              w_stall;
  logic              w_abort;
  logic [1:0]        w_km1;
  logic [2:0]        w_sel_len;
  logic [31:0]       w_ext;
  logic [NUM_PORTS-1:0] w_onehot;

  assign w_cur     = addr_q + ADDR_W'(k_q);
  assign w_cur32   = 32'(w_cur);
  assign w_stall   = wr_q & (w_cur32 >= IO_BASE) & io_buffer_full;
  assign w_abort   = flush_in & ~wr_q & FLUSH_MASK[port_q];
  assign w_km1     = k_q - 2'd1;
  assign w_sel_len = w_len_arr[w_grant];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_onehot[p] = (port_q == PW'(p));
    end
  end

  always_comb begin
    case (len_q[1:0])
      2'b00:   w_ext = len_q[2] ? {24'd0, data_q[7:0]}  : {{24{data_q[7]}},  data_q[7:0]};
      2'b01:   w_ext = len_q[2] ? {16'd0, data_q[15:0]} : {{16{data_q[15]}}, data_q[15:0]};
      default: w_ext = data_q;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      port_q  <= '0;
      last_q  <= PW'(NUM_PORTS - 1);
      wr_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      k_q     <= '0;
      lastk_q <= '0;
      data_q  <= '0;
    end else begin
      port_q  <= port_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      k_q     <= k_d;
      lastk_q <= lastk_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    k_d     = k_q;
    lastk_d = lastk_q;
    data_d  = data_q;
    if (rdy_in) begin
      case (state_q)
        S_IDLE: begin
          if (w_found) begin
            state_d = S_XFER;
            port_d  = w_grant;
            wr_d    = req_wr[w_grant];
            addr_d  = w_addr_arr[w_grant];
            len_d   = w_sel_len;
            wdata_d = w_wdata_arr[w_grant];
            k_d     = 2'd0;
            data_d  = '0;
            case (w_sel_len[1:0])
              2'b00:   lastk_d = 2'd0;
              2'b01:   lastk_d = 2'd1;
              default: lastk_d = 2'd3;
            endcase
          end
        end
        S_XFER: begin
          if (w_abort) begin
            state_d = S_IDLE;
          end else if (!w_stall) begin
            // Read data lags its address by one cycle.
            if (!wr_q && (k_q != 2'd0)) data_d[{w_km1, 3'b000} +: 8] = mem_din;
            if (k_q == lastk_q) state_d = wr_q ? S_RESP : S_WAIT;
            else                k_d = k_q + 2'd1;
          end
        end
        S_WAIT: begin
          if (w_abort) begin
            state_d = S_IDLE;
          end else begin
            data_d[{lastk_q, 3'b000} +: 8] = mem_din;
            state_d = S_RESP;
          end
        end
        S_RESP: begin
          state_d = S_IDLE;
          if (!w_abort) last_d = port_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_a      = '0;
    mem_wr     = 1'b0;
    mem_dout   = '0;
    resp_valid = '0;
    resp_data  = '0;
    case (state_q)
      S_XFER: begin
        mem_a    = w_cur32;
        mem_dout = wdata_q[{k_q, 3'b000} +: 8];
        mem_wr   = wr_q & rdy_in & ~w_stall;
      end
      S_RESP: begin
        if (rdy_in && !w_abort) begin
          resp_valid = w_onehot;
          resp_data  = wr_q ? 32'd0 : w_ext;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter_unit
// Directed self-checking bench for mem_arbiter_unit with a byte RAM model.
// Revision: 1.0
// ============================================================================
module tb_mem_arbiter_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        flush_in;
  logic [1:0]  req_valid;
  logic [1:0]  req_wr;
  logic [63:0] req_addr;
  logic [5:0]  req_len;
  logic [63:0] req_wdata;
  logic [1:0]  resp_valid;
  logic [31:0] resp_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram [0:4095];
  logic        ld_en;
  logic [11:0] ld_a;
  logic [7:0]  ld_d;
  int          io_cnt = 0;
  logic [7:0]  io_last;

  logic [31:0] tr_a  [0:63];
  logic        tr_wr [0:63];
  logic [7:0]  tr_d  [0:63];

  always #5 clk_in = ~clk_in;

  mem_arbiter_unit #(
    .NUM_PORTS (2),
    .ADDR_W    (32),
    .IO_BASE   (32'h0003_0000),
    .FLUSH_MASK(2'b10)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout),
    .mem_a         (mem_a),
    .mem_wr        (mem_wr),
    .io_buffer_full(io_buffer_full),
    .flush_in      (flush_in),
    .req_valid     (req_valid),
    .req_wr        (req_wr),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data)
  );

  // RAM below IO_BASE, write log above it; read data appears one cycle later.
  always @(posedge clk_in) begin
    if (ld_en) ram[ld_a] <= ld_d;
    else if (mem_wr && mem_a < 32'h0003_0000) ram[mem_a[11:0]] <= mem_dout;
    if (mem_wr && mem_a >= 32'h0003_0000) begin
      io_cnt  <= io_cnt + 1;
      io_last <= mem_dout;
    end
    mem_din <= ram[mem_a[11:0]];
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic load(input logic [11:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic set_port(input int p, input logic wr, input logic [31:0] addr,
                          input logic [2:0] len, input logic [31:0] wdata);
    req_wr[p]            = wr;
    req_addr[p*32 +: 32] = addr;
    req_len[p*3 +: 3]    = len;
    req_wdata[p*32 +: 32] = wdata;
    req_valid[p]         = 1'b1;
  endtask

  task automatic do_req(input int p, input logic wr, input logic [31:0] addr,
                        input logic [2:0] len, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic [1:0] rv);
    step();
    set_port(p, wr, addr, len, wdata);
    lat = -1; rdata = '0; rv = '0;
    for (int i = 1; i <= 30; i++) begin
      step();
      tr_a[i] = mem_a; tr_wr[i] = mem_wr; tr_d[i] = mem_dout;
      if (resp_valid != 2'b00) begin
        lat = i; rdata = resp_data; rv = resp_valid;
        req_valid[p] = 1'b0;
        break;
      end
    end
    req_valid[p] = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (2) step();
    checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL reset_mem_a: got %h expected 0", mem_a); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); end
    checks++; if (mem_dout !== 8'd0) begin errors++; $display("FAIL reset_mem_dout: got %h expected 0", mem_dout); end
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b expected 00", resp_valid); end
    checks++; if (resp_data !== 32'd0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
    rst_in = 1'b0;
    step();
  endtask

  task automatic test_lw();
    int lat; logic [31:0] rd; logic [1:0] rv;
    load(12'h100, 8'h78); load(12'h101, 8'h56); load(12'h102, 8'h34); load(12'h103, 8'h12);
    do_req(0, 1'b0, 32'h100, 3'b010, 32'd0, lat, rd, rv);
    checks++; if (lat !== 6) begin errors++; $display("FAIL lw_latency: got %0d expected 6", lat); end
    checks++; if (rv !== 2'b01) begin errors++; $display("FAIL lw_resp_port: got %b expected 01", rv); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL lw_data: got %h expected 12345678", rd); end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (tr_a[i] !== 32'h100 + 32'(i - 1)) begin
        errors++; $display("FAIL lw_addr_%0d: got %h expected %h", i, tr_a[i], 32'h100 + 32'(i - 1));
      end
    end
    checks++; if (tr_a[5] !== 32'd0) begin errors++; $display("FAIL lw_wait_bus_idle: got %h expected 0", tr_a[5]); end
    checks++; if (tr_wr[2] !== 1'b0) begin errors++; $display("FAIL lw_no_write: got %b expected 0", tr_wr[2]); end
  endtask

  task automatic test_loads();
    int lat; logic [31:0] rd; logic [1:0] rv;
    load(12'h200, 8'h80); load(12'h204, 8'h11); load(12'h210, 8'h01); load(12'h211, 8'h80);
    do_req(0, 1'b0, 32'h200, 3'b000, 32'd0, lat, rd, rv);
    checks++; if (lat !== 3) begin errors++; $display("FAIL lb_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", rd); end
    do_req(0, 1'b0, 32'h200, 3'b100, 32'd0, lat, rd, rv);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_data: got %h expected 00000080", rd); end
    do_req(0, 1'b0, 32'h210, 3'b001, 32'd0, lat, rd, rv);
    checks++; if (lat !== 4) begin errors++; $display("FAIL lh_latency: got %0d expected 4", lat); end
    checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data: got %h expected ffff8001", rd); end
    do_req(1, 1'b0, 32'h210, 3'b101, 32'd0, lat, rd, rv);
    checks++; if (rv !== 2'b10) begin errors++; $display("FAIL lhu_resp_port: got %b expected 10", rv); end
    checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu_data: got %h expected 00008001", rd); end
  endtask

  task automatic test_store();
    int lat; logic [31:0] rd; logic [1:0] rv; int nwr;
    do_req(0, 1'b1, 32'h300, 3'b010, 32'hDEADBEEF, lat, rd, rv);
    checks++; if (lat !== 5) begin errors++; $display("FAIL sw_latency: got %0d expected 5", lat); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL sw_resp_data: got %h expected 0", rd); end
    nwr = 0;
    for (int i = 1; i <= 5; i++) if (tr_wr[i] === 1'b1) nwr++;
    checks++; if (nwr !== 4) begin errors++; $display("FAIL sw_write_cycles: got %0d expected 4", nwr); end
    checks++;
    if ({ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]} !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_ram: got %h expected deadbeef",
                         {ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]});
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  ord [0:3];
    logic [31:0] dat [0:3];
    int          at  [0:3];
    logic [1:0]  exp_ord [0:3];
    logic [31:0] exp_dat [0:3];
    int n;
    exp_ord[0] = 2'b01; exp_ord[1] = 2'b10; exp_ord[2] = 2'b01; exp_ord[3] = 2'b10;
    exp_dat[0] = 32'h80; exp_dat[1] = 32'h11; exp_dat[2] = 32'h80; exp_dat[3] = 32'h11;
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    step();
    set_port(0, 1'b0, 32'h200, 3'b100, 32'd0);
    set_port(1, 1'b0, 32'h204, 3'b100, 32'd0);
    n = 0;
    for (int i = 1; i <= 40 && n < 4; i++) begin
      step();
      if (resp_valid != 2'b00) begin
        ord[n] = resp_valid; dat[n] = resp_data; at[n] = i; n++;
      end
    end
    req_valid = 2'b00;
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_count: got %0d expected 4", n); end
    for (int j = 0; j < 4; j++) begin
      if (j < n) begin
        checks++; if (ord[j] !== exp_ord[j]) begin errors++; $display("FAIL rr_order_%0d: got %b expected %b", j, ord[j], exp_ord[j]); end
        checks++; if (dat[j] !== exp_dat[j]) begin errors++; $display("FAIL rr_data_%0d: got %h expected %h", j, dat[j], exp_dat[j]); end
        checks++; if (at[j] !== 3 + 4 * j) begin errors++; $display("FAIL rr_time_%0d: got %0d expected %0d", j, at[j], 3 + 4 * j); end
      end
    end
  endtask

  task automatic test_io_stall();
    int lat; int c0; int nwr;
    step();
    set_port(0, 1'b1, 32'h0003_0000, 3'b000, 32'h41);
    io_buffer_full = 1'b1;
    c0 = io_cnt;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 4) io_buffer_full = 1'b0;
      #1;
      tr_a[i] = mem_a; tr_wr[i] = mem_wr; tr_d[i] = mem_dout;
      if (resp_valid != 2'b00) begin lat = i; req_valid[0] = 1'b0; break; end
    end
    req_valid[0] = 1'b0;
    io_buffer_full = 1'b0;
    checks++; if (lat !== 5) begin errors++; $display("FAIL io_latency: got %0d expected 5", lat); end
    nwr = 0;
    for (int i = 1; i <= 3; i++) if (tr_wr[i] !== 1'b0) nwr++;
    checks++; if (nwr !== 0) begin errors++; $display("FAIL io_stall_writes: got %0d expected 0", nwr); end
    checks++; if (tr_wr[4] !== 1'b1) begin errors++; $display("FAIL io_write_cycle: got %b expected 1", tr_wr[4]); end
    checks++; if (tr_a[4] !== 32'h0003_0000) begin errors++; $display("FAIL io_addr: got %h expected 00030000", tr_a[4]); end
    checks++; if (tr_d[4] !== 8'h41) begin errors++; $display("FAIL io_dout: got %h expected 41", tr_d[4]); end
    checks++; if (io_cnt - c0 !== 1) begin errors++; $display("FAIL io_write_count: got %0d expected 1", io_cnt - c0); end
  endtask

  task automatic test_flush();
    int lat; logic [31:0] rd; logic got1; logic [1:0] rv;
    step();
    set_port(1, 1'b0, 32'h100, 3'b010, 32'd0);
    lat = -1; rd = '0; got1 = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (i == 1) set_port(0, 1'b0, 32'h200, 3'b000, 32'd0);
      if (i == 3) flush_in = 1'b1;
      if (i == 4) begin flush_in = 1'b0; req_valid[1] = 1'b0; end
      #1;
      tr_a[i] = mem_a;
      if (resp_valid[1]) got1 = 1'b1;
      if (resp_valid[0] && lat < 0) begin lat = i; rd = resp_data; req_valid[0] = 1'b0; end
    end
    req_valid = 2'b00;
    checks++; if (tr_a[3] !== 32'h102) begin errors++; $display("FAIL flush_pre_addr: got %h expected 00000102", tr_a[3]); end
    checks++; if (tr_a[4] !== 32'd0) begin errors++; $display("FAIL flush_idle: got %h expected 0", tr_a[4]); end
    checks++; if (got1 !== 1'b0) begin errors++; $display("FAIL flush_suppressed: got %b expected 0", got1); end
    checks++; if (tr_a[5] !== 32'h200) begin errors++; $display("FAIL flush_next_addr: got %h expected 00000200", tr_a[5]); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL flush_next_latency: got %0d expected 7", lat); end
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL flush_next_data: got %h expected ffffff80", rd); end

    step();
    set_port(1, 1'b1, 32'h400, 3'b010, 32'hCAFEF00D);
    lat = -1; rv = '0;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (i == 3) flush_in = 1'b1;
      if (i == 4) flush_in = 1'b0;
      #1;
      if (resp_valid != 2'b00) begin lat = i; rv = resp_valid; req_valid[1] = 1'b0; break; end
    end
    req_valid = 2'b00;
    flush_in = 1'b0;
    checks++; if (lat !== 5) begin errors++; $display("FAIL flush_sw_latency: got %0d expected 5", lat); end
    checks++; if (rv !== 2'b10) begin errors++; $display("FAIL flush_sw_port: got %b expected 10", rv); end
    checks++;
    if ({ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]} !== 32'hCAFEF00D) begin
      errors++; $display("FAIL flush_sw_ram: got %h expected cafef00d",
                         {ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]});
    end
  endtask

  task automatic test_rdy();
    int lat; logic [31:0] rd; int nwr;
    step();
    set_port(0, 1'b1, 32'h500, 3'b010, 32'h11223344);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 2) rdy_in = 1'b0;
      if (i == 4) rdy_in = 1'b1;
      #1;
      tr_wr[i] = mem_wr;
      if (resp_valid != 2'b00) begin lat = i; req_valid[0] = 1'b0; break; end
    end
    req_valid[0] = 1'b0;
    rdy_in = 1'b1;
    nwr = 0;
    for (int i = 1; i <= 7; i++) if (tr_wr[i] === 1'b1) nwr++;
    checks++; if (lat !== 7) begin errors++; $display("FAIL rdy_sw_latency: got %0d expected 7", lat); end
    checks++; if (tr_wr[2] !== 1'b0) begin errors++; $display("FAIL rdy_wr_forced_low: got %b expected 0", tr_wr[2]); end
    checks++; if (nwr !== 4) begin errors++; $display("FAIL rdy_write_cycles: got %0d expected 4", nwr); end
    checks++;
    if ({ram[12'h503], ram[12'h502], ram[12'h501], ram[12'h500]} !== 32'h11223344) begin
      errors++; $display("FAIL rdy_sw_ram: got %h expected 11223344",
                         {ram[12'h503], ram[12'h502], ram[12'h501], ram[12'h500]});
    end

    step();
    set_port(0, 1'b0, 32'h200, 3'b000, 32'd0);
    lat = -1; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 3) rdy_in = 1'b0;
      if (i == 5) rdy_in = 1'b1;
      #1;
      if (resp_valid != 2'b00) begin lat = i; rd = resp_data; req_valid[0] = 1'b0; break; end
    end
    req_valid[0] = 1'b0;
    rdy_in = 1'b1;
    checks++; if (lat !== 5) begin errors++; $display("FAIL rdy_resp_latency: got %0d expected 5", lat); end
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL rdy_resp_data: got %h expected ffffff80", rd); end
  endtask

  task automatic test_async_reset();
    int lat; logic [31:0] rd; logic [1:0] rv;
    step();
    set_port(0, 1'b1, 32'h600, 3'b010, 32'hA5A5A5A5);
    step();
    step();
    checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL areset_pre_wr: got %b expected 1", mem_wr); end
    #2;
    rst_in = 1'b1;
    #1;
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL areset_mem_wr: got %b expected 0", mem_wr); end
    checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL areset_mem_a: got %h expected 0", mem_a); end
    checks++; if (mem_dout !== 8'd0) begin errors++; $display("FAIL areset_mem_dout: got %h expected 0", mem_dout); end
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL areset_resp_valid: got %b expected 00", resp_valid); end
    req_valid = 2'b00;
    step();
    rst_in = 1'b0;
    do_req(0, 1'b0, 32'h100, 3'b010, 32'd0, lat, rd, rv);
    checks++; if (lat !== 6) begin errors++; $display("FAIL areset_after_latency: got %0d expected 6", lat); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL areset_after_data: got %h expected 12345678", rd); end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0; flush_in = 1'b0;
    req_valid = '0; req_wr = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    ld_en = 1'b0; ld_a = '0; ld_d = '0;
    test_reset();
    test_lw();
    test_loads();
    test_store();
    test_round_robin();
    test_io_stall();
    test_flush();
    test_rdy();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
